// File: rtl/uart_tx_string_param.sv
// uart_tx_string_param: buffered multi-byte UART transmitter.
// Frame format is set by parameters; baud is latched per string.
module uart_tx_string_param #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int MAX_LEN   = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
   localparam int LW = $clog2(MAX_LEN + 1)
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Wr_En,
   input  logic [AW-1:0]        Wr_Addr,
   input  logic [DATA_BITS-1:0] Wr_Data,
   input  logic                 Send_En,
   input  logic [LW-1:0]        Str_Len,
   input  logic [2:0]           Baud_Set,
   output logic                 Rs232_Tx,
   output logic                 Tx_Busy,
   output logic                 Byte_Done,
   output logic                 Str_Done,
   output logic [AW-1:0]        Byte_Cnt
);

   localparam int P0 = CLK_FREQ / 9600;
   localparam int P1 = CLK_FREQ / 19200;
   localparam int P2 = CLK_FREQ / 38400;
   localparam int P3 = CLK_FREQ / 57600;
   localparam int P4 = CLK_FREQ / 115200;
   localparam int CW = $clog2(P0 + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [CW-1:0]        per_q, per_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [LW-1:0]        len_q, len_d;
   logic [AW-1:0]        idx_q, idx_d;
   logic                 zero_q, zero_d;

   logic [DATA_BITS-1:0] buf_q [MAX_LEN];

   logic [CW-1:0] per_sel;
   logic [LW-1:0] len_in;
   logic          tick;
   logic          last;
   logic          load;

   function automatic logic par_of(input logic [DATA_BITS-1:0] v);
      return (PARITY == 1) ? ~(^v) : ^v;
   endfunction

   always_comb begin
      unique case (Baud_Set)
         3'd0:    per_sel = CW'(P0);
         3'd1:    per_sel = CW'(P1);
         3'd2:    per_sel = CW'(P2);
         3'd3:    per_sel = CW'(P3);
         default: per_sel = CW'(P4);
      endcase
   end

   assign len_in = (int'(Str_Len) > MAX_LEN) ? LW'(MAX_LEN) : Str_Len;
   assign tick   = (cnt_q == per_q - CW'(1));
   assign last   = ((LW'(idx_q) + LW'(1)) == len_q);

   // Buffer is deliberately left out of reset.
   always_ff @(posedge Clk) begin
      if (Wr_En) buf_q[Wr_Addr] <= Wr_Data;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      len_d   = len_q;
      idx_d   = idx_q;
      zero_d  = 1'b0;
      load    = 1'b0;

      if (state_q != S_IDLE) cnt_d = tick ? '0 : cnt_q + CW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (Send_En) begin
               if (len_in == '0) begin
                  zero_d = 1'b1;
               end else begin
                  len_d   = len_in;
                  per_d   = per_sel;
                  idx_d   = '0;
                  cnt_d   = '0;
                  state_d = S_START;
                  load    = 1'b1;
               end
            end
         end
         S_START: begin
            if (tick) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_PAR: begin
            if (tick) begin
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (bit_q == 3'(STOP_BITS - 1)) begin
                  if (last) begin
                     state_d = S_IDLE;
                     idx_d   = '0;
                  end else begin
                     state_d = S_START;
                     idx_d   = idx_q + AW'(1);
                     load    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Byte is captured as its start bit begins.
      if (load) begin
         shift_d = buf_q[idx_d];
         par_d   = par_of(buf_q[idx_d]);
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         per_q   <= CW'(P4);
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         len_q   <= '0;
         idx_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      unique case (state_q)
         S_START: Rs232_Tx = 1'b0;
         S_DATA:  Rs232_Tx = shift_q[0];
         S_PAR:   Rs232_Tx = par_q;
         default: Rs232_Tx = 1'b1;
      endcase
   end

   assign Tx_Busy   = (state_q != S_IDLE);
   assign Byte_Done = (state_q == S_STOP) && (bit_q == 3'(STOP_BITS - 1)) && tick;
   assign Str_Done  = zero_q | (Byte_Done & last);
   assign Byte_Cnt  = idx_q;

endmodule
